mult_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined 64x64 -> 128-bit multiplier between N_REQ requesters in the ElGamal datapath, for example the square and multiply paths of modular exponentiation. Requests and results use valid/ready streams. Each issued operation is tagged with its requester ID in an in-order tag FIFO, and each result is routed back to the requester that issued it. Up to MAX_OUT operations may be in flight inside the multiplier pipeline at once.

---
 rtl/mult_arbiter_if.sv | 42 ++++
 rtl/mult_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// Bundle of request, response, multiplier and status signals around mult_arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters plus multiplier.
interface mult_arbiter_if #(
    parameter int N_REQ   = 2,
    parameter int MAX_OUT = 4,
    parameter int W       = 64
);
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [N_REQ*W-1:0] req_a_tdata;
    logic [N_REQ*W-1:0] req_b_tdata;
    logic [N_REQ-1:0]   req_tvalid;
    logic [N_REQ-1:0]   req_tready;
    logic [2*W-1:0]     rsp_tdata;
    logic [N_REQ-1:0]   rsp_tvalid;
    logic [N_REQ-1:0]   rsp_tready;
    logic [W-1:0]       m_a_tdata;
    logic [W-1:0]       m_b_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic [2*W-1:0]     m_res_tdata;
    logic               m_res_tvalid;
    logic               m_res_tready;
    logic [OW-1:0]      outstanding;
    logic               tag_err;

    modport slave (
        input  req_a_tdata, req_b_tdata, req_tvalid, rsp_tready,
        input  m_tready, m_res_tdata, m_res_tvalid,
        output req_tready, rsp_tdata, rsp_tvalid,
        output m_a_tdata, m_b_tdata, m_tvalid, m_res_tready,
        output outstanding, tag_err
    );

    modport master (
        output req_a_tdata, req_b_tdata, req_tvalid, rsp_tready,
        output m_tready, m_res_tdata, m_res_tvalid,
        input  req_tready, rsp_tdata, rsp_tvalid,
        input  m_a_tdata, m_b_tdata, m_tvalid, m_res_tready,
        input  outstanding, tag_err
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier among N_REQ requesters, with an in-order
// tag FIFO routing products back. Define MULT_ARB_PRIO_EN to give requester 0 fixed top priority.
module mult_arbiter #(
    parameter int N_REQ   = 2,
    parameter int MAX_OUT = 4,
    parameter int W       = 64
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave arb_io
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW  = $clog2(MAX_OUT) + 1;
    localparam logic [OW-1:0]  MAX_CNT = OW'(MAX_OUT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
`ifdef MULT_ARB_PRIO_EN
    localparam logic [IDW-1:0] RR_FIRST = IDW'(1);
`else
    localparam logic [IDW-1:0] RR_FIRST = '0;
`endif

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_q;
    logic [IDW-1:0] hold_gnt_q;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic           tag_err_q;
    logic [IDW-1:0] tag_mem [MAX_OUT];

    logic [W-1:0]   a_arr [N_REQ];
    logic [W-1:0]   b_arr [N_REQ];
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic           grant_exists;
    logic           sel_valid;
    logic [IDW-1:0] sel_idx;
    logic           issue;
    logic           fifo_empty;
    logic           pop;
    logic           drop;
    logic [IDW-1:0] head_tag;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign a_arr[gi] = arb_io.req_a_tdata[gi*W +: W];
        assign b_arr[gi] = arb_io.req_b_tdata[gi*W +: W];
        assign arb_io.req_tready[gi] = issue && (sel_idx == IDW'(gi));
        assign arb_io.rsp_tvalid[gi] = !rst && !fifo_empty && arb_io.m_res_tvalid
                                       && (head_tag == IDW'(gi));
    end

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int cand;
        logic [N_REQ-1:0] rot;
        cand      = 0;
        rot       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
`ifdef MULT_ARB_PRIO_EN
        if (arb_io.req_tvalid[0]) begin
            gnt_found = 1'b1;
        end else begin
            for (int off = 0; off < N_REQ - 1; off++) begin
                cand = 1 + ((int'(rr_ptr_q) - 1 + off) % (N_REQ - 1));
                rot  = arb_io.req_tvalid >> cand;
                if (!gnt_found && rot[0]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDW'(cand);
                end
            end
        end
`else
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(rr_ptr_q) + off) % N_REQ;
            rot  = arb_io.req_tvalid >> cand;
            if (!gnt_found && rot[0]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
`endif
    end

    // HOLD pins the latched grant so the offered operands cannot change under the multiplier.
    always_comb begin
        if (state_q == HOLD) begin
            sel_valid = 1'b1;
            sel_idx   = hold_gnt_q;
        end else begin
            sel_valid = gnt_found && (outstanding_q < MAX_CNT);
            sel_idx   = gnt_idx;
        end
    end

    assign grant_exists     = !rst && ((state_q == HOLD) || gnt_found);
    assign issue            = !rst && sel_valid && arb_io.m_tready;
    assign arb_io.m_tvalid  = !rst && sel_valid;
    assign arb_io.m_a_tdata = grant_exists ? a_arr[sel_idx] : '0;
    assign arb_io.m_b_tdata = grant_exists ? b_arr[sel_idx] : '0;

    assign fifo_empty          = (outstanding_q == '0);
    assign head_tag            = tag_mem[rd_ptr_q];
    assign arb_io.rsp_tdata    = (!rst && !fifo_empty) ? arb_io.m_res_tdata : '0;
    // An untagged product is swallowed so a stale pipeline cannot wedge the multiplier.
    assign arb_io.m_res_tready = !rst && (fifo_empty ? arb_io.m_res_tvalid
                                                     : arb_io.rsp_tready[head_tag]);
    assign pop  = !rst && !fifo_empty && arb_io.m_res_tvalid && arb_io.rsp_tready[head_tag];
    assign drop = !rst && fifo_empty && arb_io.m_res_tvalid;

    assign arb_io.outstanding = outstanding_q;
    assign arb_io.tag_err     = tag_err_q;

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && pop) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
`ifdef MULT_ARB_PRIO_EN
            if (sel_idx != '0) begin
                rr_ptr_d = (sel_idx == LAST_ID) ? RR_FIRST : sel_idx + 1'b1;
            end
`else
            rr_ptr_d = (sel_idx == LAST_ID) ? RR_FIRST : sel_idx + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_gnt_q    <= '0;
            rr_ptr_q      <= RR_FIRST;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            tag_err_q     <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            if (issue) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                tag_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (sel_valid && !arb_io.m_tready) begin
                        state_q    <= HOLD;
                        hold_gnt_q <= gnt_idx;
                    end
                end
                HOLD: begin
                    if (arb_io.m_tready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr_q] <= sel_idx;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: 3-cycle multiplier model plus an in-order scoreboard of
// {requester, product} pushed at issue and popped at each accepted response.
module tb_mult_arbiter;
    localparam int N_REQ   = 2;
    localparam int MAX_OUT = 4;
    localparam int W       = 64;
    localparam int LAT     = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   rr_exp = 0;

    always #5 clk = ~clk;

    mult_arbiter_if #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT), .W(W)) arb_io ();

    mult_arbiter #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_io (arb_io)
    );

    // Multiplier model: fixed latency, holds its head product until accepted.
    typedef struct { logic [2*W-1:0] prod; int rdy; } mop_t;
    mop_t mq[$];
    int   cyc = 0;

    always @(posedge clk) begin
        mop_t m;
        if (arb_io.m_res_tvalid && arb_io.m_res_tready) void'(mq.pop_front());
        if (arb_io.m_tvalid && arb_io.m_tready) begin
            m.prod = {{W{1'b0}}, arb_io.m_a_tdata} * {{W{1'b0}}, arb_io.m_b_tdata};
            m.rdy  = cyc + LAT;
            mq.push_back(m);
        end
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].rdy <= cyc) begin
            arb_io.m_res_tvalid = 1'b1;
            arb_io.m_res_tdata  = mq[0].prod;
        end else begin
            arb_io.m_res_tvalid = 1'b0;
            arb_io.m_res_tdata  = '0;
        end
    end

    typedef struct { int id; logic [2*W-1:0] prod; } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        if (!rst) begin
            for (int g = 0; g < N_REQ; g++) begin
                if (arb_io.req_tready[g] === 1'b1) begin
                    a = arb_io.req_a_tdata[g*W +: W];
                    b = arb_io.req_b_tdata[g*W +: W];
                    e.id   = g;
                    e.prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    sb.push_back(e);
                end
            end
            for (int g = 0; g < N_REQ; g++) begin
                if (arb_io.rsp_tvalid[g] === 1'b1 && arb_io.rsp_tready[g] === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got product %h at requester %0d, required none",
                                 arb_io.rsp_tdata, g);
                    end else begin
                        e = sb.pop_front();
                        if (g != e.id || arb_io.rsp_tdata !== e.prod) begin
                            errors++;
                            $display("FAIL sb_route: got req %0d data %h, required req %0d data %h",
                                     g, arb_io.rsp_tdata, e.id, e.prod);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arb_io.req_a_tdata = '0;
        arb_io.req_b_tdata = '0;
        arb_io.req_tvalid  = '0;
        arb_io.rsp_tready  = '0;
        arb_io.m_tready    = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({arb_io.req_tready, arb_io.rsp_tvalid, arb_io.m_tvalid, arb_io.m_res_tready} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got rq=%b rv=%b mv=%b mr=%b, required all 0",
                     arb_io.req_tready, arb_io.rsp_tvalid, arb_io.m_tvalid, arb_io.m_res_tready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (arb_io.outstanding !== '0 || arb_io.tag_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got outstanding=%0d tag_err=%b, required 0 0",
                     arb_io.outstanding, arb_io.tag_err);
        end
        checks++;
        if ({arb_io.m_a_tdata, arb_io.m_b_tdata, arb_io.rsp_tdata, arb_io.m_tvalid} !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%h b=%h rsp=%h mv=%b, required all 0",
                     arb_io.m_a_tdata, arb_io.m_b_tdata, arb_io.rsp_tdata, arb_io.m_tvalid);
        end
    endtask

    task automatic test_single();
        step();
        arb_io.req_a_tdata = {64'h0, 64'h2};
        arb_io.req_b_tdata = {64'h0, 64'h3};
        arb_io.req_tvalid  = 2'b01;
        arb_io.m_tready    = 1'b1;
        arb_io.rsp_tready  = 2'b11;
        @(negedge clk);
        checks++;
        if (arb_io.req_tready !== 2'b01 || arb_io.m_a_tdata !== 64'h2 || arb_io.m_b_tdata !== 64'h3) begin
            errors++;
            $display("FAIL single_issue: got rq=%b a=%h b=%h, required 01 2 3",
                     arb_io.req_tready, arb_io.m_a_tdata, arb_io.m_b_tdata);
        end
        step();
        arb_io.req_tvalid = 2'b00;
        @(negedge clk);
        checks++;
        if (arb_io.outstanding !== 3'd1 || arb_io.rsp_tvalid !== 2'b00) begin
            errors++;
            $display("FAIL single_c1: got outstanding=%0d rv=%b, required 1 00",
                     arb_io.outstanding, arb_io.rsp_tvalid);
        end
        step();
        @(negedge clk);
        checks++;
        if (arb_io.rsp_tvalid !== 2'b00) begin
            errors++;
            $display("FAIL single_c2: got rv=%b, required 00", arb_io.rsp_tvalid);
        end
        step();
        @(negedge clk);
        checks++;
        if (arb_io.rsp_tvalid !== 2'b01 || arb_io.rsp_tdata !== 128'h6 || arb_io.outstanding !== 3'd1) begin
            errors++;
            $display("FAIL single_rsp: got rv=%b data=%h outstanding=%0d, required 01 6 1",
                     arb_io.rsp_tvalid, arb_io.rsp_tdata, arb_io.outstanding);
        end
        step();
        @(negedge clk);
        checks++;
        if (arb_io.outstanding !== 3'd0) begin
            errors++;
            $display("FAIL single_done: got outstanding=%0d, required 0", arb_io.outstanding);
        end
        rr_exp = 1;
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] exp_vec;
        int g;
        step();
        arb_io.req_a_tdata = {64'd11, 64'd5};
        arb_io.req_b_tdata = {64'd13, 64'd7};
        arb_io.req_tvalid  = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef MULT_ARB_PRIO_EN
            g = 0;
`else
            g = rr_exp;
            rr_exp = (g + 1) % N_REQ;
`endif
            exp_vec = '0;
            exp_vec[g] = 1'b1;
            checks++;
            if (arb_io.req_tready !== exp_vec) begin
                errors++;
                $display("FAIL fair_grant%0d: got rq=%b, required %b", i, arb_io.req_tready, exp_vec);
            end
        end
        step();
        arb_io.req_tvalid = 2'b00;
        for (int i = 0; i < 40 && arb_io.outstanding !== '0; i++) @(negedge clk);
        checks++;
        if (arb_io.outstanding !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL fair_drain: got outstanding=%0d pending=%0d, required 0 0",
                     arb_io.outstanding, sb.size());
        end
    endtask

    task automatic test_full();
        int issues = 0;
        step();
        arb_io.req_a_tdata = {64'd0, 64'h1234_5678_9ABC_DEF0};
        arb_io.req_b_tdata = {64'd0, 64'h0FED_CBA9_8765_4321};
        arb_io.req_tvalid  = 2'b01;
        arb_io.rsp_tready  = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (arb_io.req_tready[0] === 1'b1) issues++;
        end
        checks++;
        if (issues != MAX_OUT || arb_io.outstanding !== 3'd4 || arb_io.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_cap: got issues=%0d outstanding=%0d mv=%b, required 4 4 0",
                     issues, arb_io.outstanding, arb_io.m_tvalid);
        end
        step();
        arb_io.rsp_tready = 2'b11;
        @(negedge clk);
        checks++;
        if (arb_io.m_tvalid !== 1'b0 || arb_io.rsp_tvalid !== 2'b01 || arb_io.m_res_tready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: got mv=%b rv=%b mr=%b, required 0 01 1",
                     arb_io.m_tvalid, arb_io.rsp_tvalid, arb_io.m_res_tready);
        end
        step();
        arb_io.rsp_tready = 2'b00;
        @(negedge clk);
        checks++;
        if (arb_io.outstanding !== 3'd3 || arb_io.m_tvalid !== 1'b1 || arb_io.req_tready !== 2'b01) begin
            errors++;
            $display("FAIL full_reissue: got outstanding=%0d mv=%b rq=%b, required 3 1 01",
                     arb_io.outstanding, arb_io.m_tvalid, arb_io.req_tready);
        end
        step();
        @(negedge clk);
        checks++;
        if (arb_io.outstanding !== 3'd4 || arb_io.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_refill: got outstanding=%0d mv=%b, required 4 0",
                     arb_io.outstanding, arb_io.m_tvalid);
        end
        step();
        arb_io.req_tvalid = 2'b00;
        arb_io.rsp_tready = 2'b11;
        for (int i = 0; i < 40 && arb_io.outstanding !== '0; i++) @(negedge clk);
        checks++;
        if (arb_io.outstanding !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got outstanding=%0d pending=%0d, required 0 0",
                     arb_io.outstanding, sb.size());
        end
        rr_exp = 1;
    endtask

    task automatic test_hold();
        step();
        arb_io.req_a_tdata = {64'h1111, 64'hAAAA};
        arb_io.req_b_tdata = {64'h2222, 64'hBBBB};
        arb_io.req_tvalid  = 2'b10;
        arb_io.m_tready    = 1'b0;
        @(negedge clk);
        checks++;
        if (arb_io.m_tvalid !== 1'b1 || arb_io.m_a_tdata !== 64'h1111 || arb_io.req_tready !== 2'b00) begin
            errors++;
            $display("FAIL hold_c0: got mv=%b a=%h rq=%b, required 1 1111 00",
                     arb_io.m_tvalid, arb_io.m_a_tdata, arb_io.req_tready);
        end
        step();
        arb_io.req_tvalid = 2'b11;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (arb_io.m_a_tdata !== 64'h1111 || arb_io.m_b_tdata !== 64'h2222 ||
                arb_io.m_tvalid !== 1'b1 || arb_io.req_tready !== 2'b00) begin
                errors++;
                $display("FAIL hold_c%0d: got a=%h b=%h mv=%b rq=%b, required 1111 2222 1 00",
                         i, arb_io.m_a_tdata, arb_io.m_b_tdata, arb_io.m_tvalid, arb_io.req_tready);
            end
            if (i < 2) step();
        end
        step();
        arb_io.m_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (arb_io.req_tready !== 2'b10 || arb_io.m_a_tdata !== 64'h1111) begin
            errors++;
            $display("FAIL hold_accept: got rq=%b a=%h, required 10 1111",
                     arb_io.req_tready, arb_io.m_a_tdata);
        end
        step();
        arb_io.req_tvalid = 2'b01;
        @(negedge clk);
        checks++;
        if (arb_io.req_tready !== 2'b01 || arb_io.m_a_tdata !== 64'hAAAA) begin
            errors++;
            $display("FAIL hold_next: got rq=%b a=%h, required 01 aaaa",
                     arb_io.req_tready, arb_io.m_a_tdata);
        end
        step();
        arb_io.req_tvalid = 2'b00;
        for (int i = 0; i < 40 && arb_io.outstanding !== '0; i++) @(negedge clk);
        checks++;
        if (arb_io.outstanding !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL hold_drain: got outstanding=%0d pending=%0d, required 0 0",
                     arb_io.outstanding, sb.size());
        end
        rr_exp = 1;
    endtask

    task automatic test_routing();
        logic [2*W-1:0] sq;
        logic [N_REQ-1:0] order [3];
        sq = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        order[0] = 2'b10;
        order[1] = 2'b01;
        order[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            arb_io.req_a_tdata = '1;
            arb_io.req_b_tdata = '1;
            arb_io.req_tvalid  = order[i];
            @(negedge clk);
            checks++;
            if (arb_io.req_tready !== order[i]) begin
                errors++;
                $display("FAIL route_issue%0d: got rq=%b, required %b", i, arb_io.req_tready, order[i]);
            end
        end
        step();
        arb_io.req_tvalid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (arb_io.rsp_tvalid !== order[i] || arb_io.rsp_tdata !== sq) begin
                errors++;
                $display("FAIL route_rsp%0d: got rv=%b data=%h, required %b %h",
                         i, arb_io.rsp_tvalid, arb_io.rsp_tdata, order[i], sq);
            end
            step();
        end
        for (int i = 0; i < 40 && arb_io.outstanding !== '0; i++) @(negedge clk);
        checks++;
        if (arb_io.outstanding !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL route_drain: got outstanding=%0d pending=%0d, required 0 0",
                     arb_io.outstanding, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        step();
        arb_io.req_a_tdata = {64'd0, 64'd5};
        arb_io.req_b_tdata = {64'd0, 64'd6};
        arb_io.req_tvalid  = 2'b01;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (arb_io.outstanding !== 3'd1 || arb_io.req_tready !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_issue: got outstanding=%0d rq=%b, required 1 01",
                     arb_io.outstanding, arb_io.req_tready);
        end
        step();
        arb_io.req_tvalid = 2'b00;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (arb_io.m_tvalid !== 1'b0 || arb_io.m_res_tready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_hold: got mv=%b mr=%b, required 0 0", arb_io.m_tvalid, arb_io.m_res_tready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (arb_io.rsp_tvalid !== 2'b00 || arb_io.m_res_tready !== 1'b1 ||
            arb_io.outstanding !== '0 || arb_io.tag_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop1: got rv=%b mr=%b outstanding=%0d tag_err=%b, required 00 1 0 0",
                     arb_io.rsp_tvalid, arb_io.m_res_tready, arb_io.outstanding, arb_io.tag_err);
        end
        step();
        @(negedge clk);
        checks++;
        if (arb_io.rsp_tvalid !== 2'b00 || arb_io.m_res_tready !== 1'b1 || arb_io.tag_err !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_drop2: got rv=%b mr=%b tag_err=%b, required 00 1 1",
                     arb_io.rsp_tvalid, arb_io.m_res_tready, arb_io.tag_err);
        end
        step();
        @(negedge clk);
        checks++;
        if (arb_io.tag_err !== 1'b1 || arb_io.outstanding !== '0 || arb_io.rsp_tvalid !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_sticky: got tag_err=%b outstanding=%0d rv=%b, required 1 0 00",
                     arb_io.tag_err, arb_io.outstanding, arb_io.rsp_tvalid);
        end
    endtask

    initial begin
        arb_io.m_res_tvalid = 1'b0;
        arb_io.m_res_tdata  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_hold();
        test_routing();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end
endmodule
